// File: rtl/mem_req_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory-port signals around mem_req_arbiter.
// Latency: none (wires only).
// Backpressure: carried by m_addr_ok/m_data_ok and the held x_req/x_data_ok handshakes.
// Ports: master = arbiter view (takes requests, drives memory port and completions);
//        slave  = environment view (requesters + memory).
interface mem_req_arbiter_if;
    logic        i_req;
    logic [31:0] i_vaddr;
    logic [31:0] i_rdata;
    logic        i_data_ok;

    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_vaddr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_data_ok;

    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_uncached;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    modport master (
        input  i_req, i_vaddr, d_req, d_wr, d_size, d_wstrb, d_vaddr, d_wdata,
               m_addr_ok, m_data_ok, m_rdata,
        output i_rdata, i_data_ok, d_rdata, d_data_ok,
               m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata, m_uncached
    );

    modport slave (
        output i_req, i_vaddr, d_req, d_wr, d_size, d_wstrb, d_vaddr, d_wdata,
               m_addr_ok, m_data_ok, m_rdata,
        input  i_rdata, i_data_ok, d_rdata, d_data_ok,
               m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata, m_uncached
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between fetch (I) and data (D) with kseg0/kseg1 translation, one transaction in flight.
// Latency: grant at T -> m_req at T+1; addr_ok at T+1, data_ok at T+2 -> x_data_ok pulse at T+3; IDLE again at T+4.
// Backpressure: m_req held with stable fields until m_addr_ok; requests wait in IDLE while a transaction is in flight.
// Ports: clk, resetn (synchronous, active-low); bus (master modport) carries I/D requester and memory signals.
module mem_req_arbiter #(
    parameter bit I_KSEG1_UNCACHED = 1'b0,
    parameter bit D_FIRST          = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    mem_req_arbiter_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    // last_owner starts as the side that should lose the first tie.
    localparam logic LAST_RST = D_FIRST ? OWN_I : OWN_D;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        m_req_q, m_req_d;
    logic        m_wr_q, m_wr_d;
    logic [1:0]  m_size_q, m_size_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        m_unc_q, m_unc_d;
    logic        i_ok_q, i_ok_d;
    logic        d_ok_q, d_ok_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        grant_d;
    logic        complete;

    // kseg0/kseg1 fold onto the low 512 MiB; everything else is identity-mapped.
    function automatic logic [31:0] xlate(input logic [31:0] va);
        return (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
    endfunction

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        m_req_d      = m_req_q;
        m_wr_d       = m_wr_q;
        m_size_d     = m_size_q;
        m_wstrb_d    = m_wstrb_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_unc_d      = m_unc_q;
        i_ok_d       = 1'b0;
        d_ok_d       = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        complete     = 1'b0;
        // On a tie, D wins only if I went last.
        grant_d      = bus.d_req && (!bus.i_req || (last_owner_q == OWN_I));

        case (state_q)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d = S_ADDR;
                    m_req_d = 1'b1;
                    if (grant_d) begin
                        owner_d   = OWN_D;
                        m_addr_d  = xlate(bus.d_vaddr);
                        m_wr_d    = bus.d_wr;
                        m_size_d  = bus.d_size;
                        m_wstrb_d = bus.d_wstrb;
                        m_wdata_d = bus.d_wdata;
                        m_unc_d   = (bus.d_vaddr[31:29] == 3'b101);
                    end else begin
                        owner_d   = OWN_I;
                        m_addr_d  = xlate(bus.i_vaddr);
                        m_wr_d    = 1'b0;
                        m_size_d  = 2'd2;
                        m_wstrb_d = 4'b0000;
                        m_wdata_d = 32'd0;
                        m_unc_d   = I_KSEG1_UNCACHED && (bus.i_vaddr[31:29] == 3'b101);
                    end
                end
            end
            S_ADDR: begin
                if (bus.m_addr_ok) begin
                    m_req_d = 1'b0;
                    if (bus.m_data_ok) begin
                        complete = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.m_data_ok) begin
                    complete = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                last_owner_d = owner_q;
            end
        endcase

        // Completion: the data_ok pulse is registered, so it is high exactly while in DONE.
        if (complete) begin
            state_d = S_DONE;
            if (owner_q == OWN_D) begin
                d_ok_d    = 1'b1;
                d_rdata_d = m_wr_q ? 32'd0 : bus.m_rdata;
            end else begin
                i_ok_d    = 1'b1;
                i_rdata_d = bus.m_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= LAST_RST;
            m_req_q      <= 1'b0;
            m_wr_q       <= 1'b0;
            m_size_q     <= 2'd0;
            m_wstrb_q    <= 4'd0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
            m_unc_q      <= 1'b0;
            i_ok_q       <= 1'b0;
            d_ok_q       <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            m_req_q      <= m_req_d;
            m_wr_q       <= m_wr_d;
            m_size_q     <= m_size_d;
            m_wstrb_q    <= m_wstrb_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_unc_q      <= m_unc_d;
            i_ok_q       <= i_ok_d;
            d_ok_q       <= d_ok_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.m_req      = m_req_q;
    assign bus.m_wr       = m_wr_q;
    assign bus.m_size     = m_size_q;
    assign bus.m_wstrb    = m_wstrb_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_wdata    = m_wdata_q;
    assign bus.m_uncached = m_unc_q;
    assign bus.i_data_ok  = i_ok_q;
    assign bus.d_data_ok  = d_ok_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;

endmodule
